calc_interval: RTL and testbench
================================

Name: calc_interval

Overview:
- Backward-search compute stage directly downstream of the ROM fetch stage.
- Takes one fetched record per transaction: parameters (i, z, k, l), trace address, position, C(b), Occ(b,k-1), Occ(b,l), read symbol W[i-1] and bound D(i).
- Computes the refined suffix-array interval k' = C(b) + Occ(b,k-1) + 1 and l' = C(b) + Occ(b,l).
- Emits the surviving child entries (deletion, then match/mismatch) to the parameter stack, or reports a hit when the read is exhausted.

Parameters:
- W_IDX, 8, width of i/z/k/l fields
- W_ROM, 32, width of C and Occ data

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- valid_in  in  1  upstream record valid
- ready_out  out  1  stage can accept a record
- position_in  in  4  [1:0] = base b under test; [3:2] reserved, passed through
- addr_in  in  12  parent parameter address
- i_in, z_in, k_in, l_in  in  8 each  parent parameters; i = unprocessed symbol count
- d_i_in  in  8  lower bound D(i)
- read_i_in  in  2  read symbol W[i-1]
- occ_k_in  in  32  Occ(b,k-1)
- occ_l_in  in  32  Occ(b,l)
- c_in  in  32  C(b)
- push_valid  out  1  child entry valid
- push_ready  in  1  stack accepts entry
- push_i, push_z, push_k, push_l  out  8 each  child parameters
- push_addr  out  12  parent address (trace)
- push_position  out  4  always 4'd0 (child starts at base 0)
- hit_valid  out  1  one-cycle hit pulse
- hit_k, hit_l, hit_z  out  8 each  hit interval and remaining mismatches
- err_ovf  out  1  sticky: k' or l' exceeded 255
- err_i0  out  1  sticky: record received with i_in==0

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - ready_out=1.
  - All other outputs 0, including push_* fields, hit_* fields and err flags.
  - Registered record cleared.
- Reset mid-operation discards any pending pushes; no partial entry is issued after rst_n rises.
- FSM states: IDLE, CALC, PUSH_DEL, PUSH_MM.
- IDLE:
  - ready_out=1.
  - valid_in&ready_out captures all inputs into registers and moves to CALC.
  - ready_out=0 in every other state.
- CALC (1 cycle), computed in 33-bit unsigned:
  - kn = c+occ_k+1, ln = c+occ_l.
  - empty = kn>ln.
  - ovf = ln>255 (when non-empty); ovf sets err_ovf and makes the record empty.
  - del_ok = !empty & z>0 & (z-1)>=d_i.
  - mm_ok = !empty & i>0 & (b==read_i | z>0).
  - i==0 sets err_i0 and forces mm_ok=0.
  - Next state: PUSH_DEL if del_ok, else PUSH_MM if mm_ok, else IDLE.
- PUSH_DEL:
  - Drives push_valid=1 with (i, z-1, kn[7:0], ln[7:0]).
  - Fields are held stable until push_ready.
  - On the handshake, go to PUSH_MM if mm_ok, else IDLE.
- PUSH_MM:
  - Child fields: i-1; z if b==read_i, else z-1; kn; ln.
  - If the child i==0: hit_valid pulses for 1 cycle with hit_k=kn, hit_l=ln, hit_z = child z. No backpressure, no push. Go to IDLE.
  - Otherwise push_valid=1 held until push_ready, then go to IDLE.
- Output timing:
  - push_valid/hit_valid are asserted only in their states; push_valid deasserts the cycle after the handshake.
  - Minimum latency is 2 cycles (capture to first push_valid/hit_valid).
  - Throughput is 1 record per 3 cycles minimum.
  - Maximum is 2 stack entries per record.
- Pruning of the match/mismatch child against D(i-1) is left to the parameter stage.
- The insertion branch is generated upstream, not here.
- The order is fixed: deletion child first, then match/mismatch child.

Test Plan:
- Reset: assert rst_n=0 mid-PUSH_DEL with push_ready=0 -> all outputs 0 immediately, ready_out=1 after release, no stale push.
- Match + deletion: c=10, occ_k=3, occ_l=7, i=5, z=1, d=0, b=read=2, push_ready=1 -> push (5,0,14,17), then push (4,1,14,17); ready_out high again on cycle 5.
- Mismatch, z=0: b=1, read=3, z=0, i=5, interval non-empty -> no pushes, no hit; back to IDLE after CALC.
- Empty interval: c=20, occ_k=5, occ_l=5 (kn=26 > ln=25) -> no output, err flags unchanged.
- Hit: i=1, z=2, d=3, b==read, c=0, occ_k=0, occ_l=4 -> deletion suppressed (1<3); hit_valid pulse with k=1, l=4, z=2.
- Backpressure/overflow: hold push_ready=0 for 4 cycles -> push fields stable, ready_out=0; separately c=250, occ_l=10 -> err_ovf=1 sticky, no pushes.

Source files
------------

// File: rtl/calc_interval.sv
// calc_interval: backward-search compute stage downstream of the ROM fetch.
// Takes one fetched record, refines the suffix-array interval
//   k' = C(b) + Occ(b,k-1) + 1,  l' = C(b) + Occ(b,l)
// and emits the deletion child, then the match/mismatch child, to the
// parameter stack, or pulses a hit when the read is exhausted.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_in / ready_out            upstream record handshake
//   position_in                     [1:0] base b under test, [3:2] reserved
//   addr_in                         parent parameter address (trace)
//   i_in, z_in, k_in, l_in          parent parameters
//   d_i_in                          lower bound D(i)
//   read_i_in                       read symbol W[i-1]
//   occ_k_in, occ_l_in, c_in        Occ(b,k-1), Occ(b,l), C(b)
//   push_valid / push_ready         child entry handshake to the stack
//   push_i/z/k/l, push_addr         child parameters and parent address
//   push_position                   always 0 (child starts at base 0)
//   hit_valid, hit_k/l/z            one-cycle hit pulse and its interval
//   err_ovf, err_i0                 sticky error flags
module calc_interval #(
    parameter int W_IDX = 8,
    parameter int W_ROM = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       position_in,
    input  logic [11:0]      addr_in,
    input  logic [W_IDX-1:0] i_in,
    input  logic [W_IDX-1:0] z_in,
    input  logic [W_IDX-1:0] k_in,
    input  logic [W_IDX-1:0] l_in,
    input  logic [W_IDX-1:0] d_i_in,
    input  logic [1:0]       read_i_in,
    input  logic [W_ROM-1:0] occ_k_in,
    input  logic [W_ROM-1:0] occ_l_in,
    input  logic [W_ROM-1:0] c_in,
    output logic             push_valid,
    input  logic             push_ready,
    output logic [W_IDX-1:0] push_i,
    output logic [W_IDX-1:0] push_z,
    output logic [W_IDX-1:0] push_k,
    output logic [W_IDX-1:0] push_l,
    output logic [11:0]      push_addr,
    output logic [3:0]       push_position,
    output logic             hit_valid,
    output logic [W_IDX-1:0] hit_k,
    output logic [W_IDX-1:0] hit_l,
    output logic [W_IDX-1:0] hit_z,
    output logic             err_ovf,
    output logic             err_i0
);

    typedef enum logic [1:0] {IDLE, CALC, PUSH_DEL, PUSH_MM} state_t;

    state_t state;

    // Registered record
    logic [W_IDX-1:0] r_i, r_z, r_d;
    logic [1:0]       r_b, r_read;
    logic [11:0]      r_addr;
    logic [W_ROM-1:0] r_c, r_occ_k, r_occ_l;

    // Results kept from CALC for the later push states
    logic [W_IDX-1:0] kn_r, ln_r, mm_z_r;
    logic             mm_ok_r;

    logic [W_ROM:0]   kn_w, ln_w;
    logic             empty_w, ovf_w, live_w, match_w, del_ok_w, mm_ok_w;
    logic [W_IDX-1:0] z_dec, mm_z_w, sel_k, sel_l, sel_z;
    logic             go_mm;

    // Parent k/l are not needed: the new interval comes from C and Occ.
    logic unused_in;
    assign unused_in = ^{position_in[3:2], k_in, l_in};

    assign push_position = '0;

    always_comb begin
        kn_w     = {1'b0, r_c} + {1'b0, r_occ_k} + (W_ROM+1)'(1);
        ln_w     = {1'b0, r_c} + {1'b0, r_occ_l};
        empty_w  = kn_w > ln_w;
        ovf_w    = !empty_w && (ln_w[W_ROM:W_IDX] != '0);
        live_w   = !empty_w && !ovf_w;
        z_dec    = r_z - W_IDX'(1);
        match_w  = (r_b == r_read);
        del_ok_w = live_w && (r_z != '0) && (z_dec >= r_d);
        mm_ok_w  = live_w && (r_i != '0) && (match_w || (r_z != '0));
        mm_z_w   = match_w ? r_z : z_dec;
        // The match/mismatch child is entered either straight from CALC
        // (values still combinational) or after the deletion handshake
        // (values held in the *_r registers).
        sel_k    = (state == CALC) ? kn_w[W_IDX-1:0] : kn_r;
        sel_l    = (state == CALC) ? ln_w[W_IDX-1:0] : ln_r;
        sel_z    = (state == CALC) ? mm_z_w : mm_z_r;
        go_mm    = ((state == CALC) && !del_ok_w && mm_ok_w) ||
                   ((state == PUSH_DEL) && push_ready && mm_ok_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_out  <= 1'b1;
            push_valid <= 1'b0;
            push_i     <= '0;
            push_z     <= '0;
            push_k     <= '0;
            push_l     <= '0;
            push_addr  <= '0;
            hit_valid  <= 1'b0;
            hit_k      <= '0;
            hit_l      <= '0;
            hit_z      <= '0;
            err_ovf    <= 1'b0;
            err_i0     <= 1'b0;
            r_i        <= '0;
            r_z        <= '0;
            r_d        <= '0;
            r_b        <= '0;
            r_read     <= '0;
            r_addr     <= '0;
            r_c        <= '0;
            r_occ_k    <= '0;
            r_occ_l    <= '0;
            kn_r       <= '0;
            ln_r       <= '0;
            mm_z_r     <= '0;
            mm_ok_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        r_i       <= i_in;
                        r_z       <= z_in;
                        r_d       <= d_i_in;
                        r_b       <= position_in[1:0];
                        r_read    <= read_i_in;
                        r_addr    <= addr_in;
                        r_c       <= c_in;
                        r_occ_k   <= occ_k_in;
                        r_occ_l   <= occ_l_in;
                        ready_out <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    kn_r      <= kn_w[W_IDX-1:0];
                    ln_r      <= ln_w[W_IDX-1:0];
                    mm_z_r    <= mm_z_w;
                    mm_ok_r   <= mm_ok_w;
                    push_addr <= r_addr;
                    if (ovf_w)
                        err_ovf <= 1'b1;
                    if (r_i == '0)
                        err_i0 <= 1'b1;
                    if (del_ok_w) begin
                        push_valid <= 1'b1;
                        push_i     <= r_i;
                        push_z     <= z_dec;
                        push_k     <= kn_w[W_IDX-1:0];
                        push_l     <= ln_w[W_IDX-1:0];
                        state      <= PUSH_DEL;
                    end else if (!mm_ok_w) begin
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                PUSH_DEL: begin
                    if (push_ready && !mm_ok_r) begin
                        push_valid <= 1'b0;
                        ready_out  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                PUSH_MM: begin
                    if (hit_valid) begin
                        hit_valid <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end else if (push_ready) begin
                        push_valid <= 1'b0;
                        ready_out  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (go_mm) begin
                state <= PUSH_MM;
                if (r_i == W_IDX'(1)) begin
                    // Child has no symbols left: report a hit, no stack entry.
                    push_valid <= 1'b0;
                    hit_valid  <= 1'b1;
                    hit_k      <= sel_k;
                    hit_l      <= sel_l;
                    hit_z      <= sel_z;
                end else begin
                    push_valid <= 1'b1;
                    push_i     <= r_i - W_IDX'(1);
                    push_z     <= sel_z;
                    push_k     <= sel_k;
                    push_l     <= sel_l;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_interval.sv
module tb_calc_interval;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  position_in;
    logic [11:0] addr_in;
    logic [7:0]  i_in, z_in, k_in, l_in, d_i_in;
    logic [1:0]  read_i_in;
    logic [31:0] occ_k_in, occ_l_in, c_in;
    logic        push_valid;
    logic        push_ready;
    logic [7:0]  push_i, push_z, push_k, push_l;
    logic [11:0] push_addr;
    logic [3:0]  push_position;
    logic        hit_valid;
    logic [7:0]  hit_k, hit_l, hit_z;
    logic        err_ovf, err_i0;

    calc_interval #(.W_IDX(8), .W_ROM(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .position_in(position_in), .addr_in(addr_in),
        .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in),
        .d_i_in(d_i_in), .read_i_in(read_i_in),
        .occ_k_in(occ_k_in), .occ_l_in(occ_l_in), .c_in(c_in),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_i(push_i), .push_z(push_z), .push_k(push_k), .push_l(push_l),
        .push_addr(push_addr), .push_position(push_position),
        .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l), .hit_z(hit_z),
        .err_ovf(err_ovf), .err_i0(err_i0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function void chk(string name, longint unsigned act, longint unsigned expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    // Expected stack entries / hits, in issue order
    typedef struct {
        bit          hit;
        int unsigned i, z, k, l, addr;
    } ev_t;
    ev_t exp_q[$];
    bit  m_ovf = 0;
    bit  m_i0  = 0;

    // Outcome of one record straight from the interval rules
    task automatic model(input int unsigned a, i, z, d, rd, b,
                         input longint unsigned c, ok, ol);
        longint unsigned kn = c + ok + 1;
        longint unsigned ln = c + ol;
        ev_t e;
        if (i == 0) m_i0 = 1;
        if (kn > ln) return;
        if (ln > 255) begin
            m_ovf = 1;
            return;
        end
        if (z > 0 && z - 1 >= d) begin
            e = '{hit: 0, i: i, z: z - 1, k: int'(kn), l: int'(ln), addr: a};
            exp_q.push_back(e);
        end
        if (i > 0 && (b == rd || z > 0)) begin
            e = '{hit: (i == 1), i: i - 1, z: (b == rd) ? z : z - 1,
                  k: int'(kn), l: int'(ln), addr: a};
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every handshake/hit is compared against the model queue
    int          n_push = 0;
    int          n_hit  = 0;
    logic [31:0] last_push = '0, prev_push = '0;
    logic [23:0] last_hit = '0;

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (push_valid && push_ready) begin
                n_push++;
                prev_push = last_push;
                last_push = {push_i, push_z, push_k, push_l};
                chk("push_position", push_position, 0);
                if (exp_q.size() == 0 || exp_q[0].hit) begin
                    chk("unexpected_push", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("push_entry", {push_i, push_z, push_k, push_l},
                        {e.i[7:0], e.z[7:0], e.k[7:0], e.l[7:0]});
                    chk("push_addr", push_addr, e.addr);
                end
            end
            if (hit_valid) begin
                n_hit++;
                last_hit = {hit_k, hit_l, hit_z};
                if (exp_q.size() == 0 || !exp_q[0].hit) begin
                    chk("unexpected_hit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hit_entry", {hit_k, hit_l, hit_z},
                        {e.k[7:0], e.l[7:0], e.z[7:0]});
                end
            end
        end
    end

    task automatic send(input int unsigned a, i, z, d, rd, b,
                        input longint unsigned c, ok, ol);
        model(a, i, z, d, rd, b, c, ok, ol);
        @(negedge clk);
        chk("ready_before_capture", ready_out, 1);
        valid_in    = 1'b1;
        addr_in     = a[11:0];
        i_in        = i[7:0];
        z_in        = z[7:0];
        k_in        = 8'hA5;
        l_in        = 8'h5A;
        d_i_in      = d[7:0];
        read_i_in   = rd[1:0];
        position_in = {2'b10, b[1:0]};
        c_in        = c[31:0];
        occ_k_in    = ok[31:0];
        occ_l_in    = ol[31:0];
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("ready_low_after_capture", ready_out, 0);
    endtask

    // Cycles after capture until ready_out returns; first_out is the cycle
    // where push_valid or hit_valid was first seen (0 = never).
    task automatic wait_idle(output int n, output int first_out);
        n = 0;
        first_out = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (first_out == 0 && (push_valid || hit_valid)) first_out = n;
        end while (!ready_out && n < 50);
        if (n >= 50) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic check_errs(string tag);
        chk({tag, "_err_ovf"}, err_ovf, m_ovf);
        chk({tag, "_err_i0"}, err_i0, m_i0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", ready_out, 1);
        chk("rst_push_valid", push_valid, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_push_fields", {push_i, push_z, push_k, push_l, push_addr, push_position}, 0);
        chk("rst_hit_fields", {hit_k, hit_l, hit_z}, 0);
        chk("rst_errs", {err_ovf, err_i0}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, fo, p0;
        logic [31:0] snap;
        logic [11:0] snap_a;

        rst_n = 1'b0; valid_in = 1'b0; push_ready = 1'b1;
        position_in = '0; addr_in = '0; i_in = '0; z_in = '0; k_in = '0;
        l_in = '0; d_i_in = '0; read_i_in = '0;
        occ_k_in = '0; occ_l_in = '0; c_in = '0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Match + deletion: (5,0,14,17) then (4,1,14,17)
        p0 = n_push;
        send(12'h101, 5, 1, 0, 2, 2, 10, 3, 7);
        wait_idle(n, fo);
        chk("t1_cycles_to_ready", n, 3);
        chk("t1_first_out_latency", fo, 1);
        chk("t1_push_count", n_push - p0, 2);
        chk("t1_first_push", prev_push, 32'h05000E11);
        chk("t1_second_push", last_push, 32'h04010E11);
        check_errs("t1");

        // Mismatch with z=0: nothing issued, straight back after CALC
        p0 = n_push;
        send(12'h102, 5, 0, 0, 3, 1, 10, 3, 7);
        wait_idle(n, fo);
        chk("t2_cycles_to_ready", n, 1);
        chk("t2_no_output", fo, 0);
        chk("t2_push_count", n_push - p0, 0);

        // Mismatch with z>0: deletion (3,1,7,14), then (2,1,7,14)
        p0 = n_push;
        send(12'h103, 3, 2, 1, 1, 0, 5, 1, 9);
        wait_idle(n, fo);
        chk("t3_push_count", n_push - p0, 2);
        chk("t3_first_push", prev_push, 32'h0301070E);
        chk("t3_second_push", last_push, 32'h0201070E);

        // Empty interval: kn=26 > ln=25
        p0 = n_push;
        send(12'h104, 4, 1, 0, 2, 2, 20, 5, 5);
        wait_idle(n, fo);
        chk("t4_no_output", fo, 0);
        chk("t4_push_count", n_push - p0, 0);
        check_errs("t4");
        chk("t4_errs_clear", {err_ovf, err_i0}, 0);

        // Hit: deletion suppressed (1<3), hit k=1 l=4 z=2
        p0 = n_hit;
        send(12'h105, 1, 2, 3, 0, 0, 0, 0, 4);
        wait_idle(n, fo);
        chk("t5_cycles_to_ready", n, 2);
        chk("t5_first_out_latency", fo, 1);
        chk("t5_hit_count", n_hit - p0, 1);
        chk("t5_hit_value", last_hit, 24'h010402);

        // Backpressure: fields stable for 4 cycles with push_ready=0
        push_ready = 1'b0;
        send(12'h106, 5, 1, 0, 2, 2, 10, 3, 7);
        @(posedge clk);
        #1;
        chk("t6_push_valid", push_valid, 1);
        snap = {push_i, push_z, push_k, push_l};
        snap_a = push_addr;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("t6_hold_valid", push_valid, 1);
            chk("t6_hold_fields", {push_i, push_z, push_k, push_l, push_addr}, {snap, snap_a});
            chk("t6_hold_ready", ready_out, 0);
        end
        push_ready = 1'b1;
        wait_idle(n, fo);

        // Overflow: ln=260 -> err_ovf, no pushes; then sticky
        p0 = n_push;
        send(12'h107, 5, 1, 0, 2, 2, 250, 0, 10);
        wait_idle(n, fo);
        chk("t7_push_count", n_push - p0, 0);
        check_errs("t7");
        chk("t7_err_ovf_literal", err_ovf, 1);

        // ln exactly 255 is legal: single match push (1,0,251,255)
        p0 = n_push;
        send(12'h108, 2, 0, 0, 3, 3, 250, 0, 5);
        wait_idle(n, fo);
        chk("t8_push_count", n_push - p0, 1);
        chk("t8_push", last_push, 32'h0100FBFF);
        check_errs("t8");

        // i==0: deletion only, err_i0 set
        p0 = n_push;
        send(12'h109, 0, 1, 0, 1, 1, 0, 0, 2);
        wait_idle(n, fo);
        chk("t9_push_count", n_push - p0, 1);
        chk("t9_push", last_push, 32'h00000102);
        check_errs("t9");
        chk("t9_err_i0_literal", err_i0, 1);

        // Reset in the middle of PUSH_DEL with push_ready=0
        push_ready = 1'b0;
        send(12'h10A, 5, 1, 0, 2, 2, 10, 3, 7);
        @(posedge clk);
        #1;
        chk("t10_in_push_del", push_valid, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_ovf = 0;
        m_i0 = 0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        push_ready = 1'b1;
        p0 = n_push;
        repeat (5) @(posedge clk);
        #1;
        chk("t10_ready_after_release", ready_out, 1);
        chk("t10_no_stale_push", n_push - p0, 0);

        // Recovery after reset
        send(12'h10B, 3, 2, 1, 1, 0, 5, 1, 9);
        wait_idle(n, fo);
        check_errs("t11");

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
